// File: rtl/tnn_pkg.sv
// Shared types for the race-logic sequencing blocks: wave FSM states and spike edge encoding.
// Spike lines idle high and fall once per wave; a line that never falls encodes infinity.
package tnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } gamma_state_t;

    localparam logic SPIKE_NONE  = 1'b1;
    localparam logic SPIKE_FIRED = 1'b0;

endpackage

// File: rtl/edge_capture.sv
// Records the step count of the first low sample of sig while en is high.
// Result registered one cycle after the sample; clear re-arms it for the next wave.
module edge_capture
    import tnn_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic          sig,
    input  logic [CW-1:0] t,
    output logic          captured,
    output logic [CW-1:0] t_cap
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured <= 1'b0;
            t_cap    <= '0;
        end else if (clear) begin
            captured <= 1'b0;
            t_cap    <= '0;
        end else if (en && !captured && (sig == SPIKE_FIRED)) begin
            captured <= 1'b1;
            t_cap    <= t;
        end
    end

endmodule

// File: rtl/gamma_ctrl.sv
// Wave sequencer: clears the primitive network, replays input spike times as falling edges, timestamps the result edge.
// Result valid T_MAX+LAT+2 cycles after start; holds in DONE until out_ready, start ignored outside IDLE.
module gamma_ctrl
    import tnn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int T_MAX = 8,
    parameter int LAT   = 1,
    parameter int TW    = $clog2(T_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [N_IN-1:0][TW-1:0] in_times,
    output logic [N_IN-1:0]      spike_out,
    output logic                 prim_rst_n,
    input  logic                 res_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        out_time
);

    localparam int CW = $clog2(T_MAX + LAT + 1);
    localparam logic [CW-1:0] LAST_T = CW'(T_MAX + LAT - 1);

    gamma_state_t state, state_nxt;

    logic [CW-1:0]           t;
    logic [N_IN-1:0][TW-1:0] times_q;
    logic                    run_en;
    logic                    last_step;
    logic                    captured;
    logic [CW-1:0]           t_cap;
    logic                    cap_now;
    logic                    hit;
    logic [CW-1:0]           t_hit;
    logic [CW-1:0]           t_adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign run_en    = (state == RUN);
    assign last_step = (t == LAST_T);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            times_q <= '0;
        end else if (state == IDLE && start) begin
            times_q <= in_times;
        end
    end

    // t freezes on the last step so DONE keeps the final spike_out pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (state == CLEAR) begin
            t <= '0;
        end else if (run_en && !last_step) begin
            t <= t + 1'b1;
        end
    end

    // Registered from the next state so the clear pulse lines up exactly with CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prim_rst_n <= 1'b0;
        end else begin
            prim_rst_n <= (state_nxt != CLEAR);
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            spike_out[i] = SPIKE_NONE;
            if ((state == RUN || state == DONE) &&
                (times_q[i] < TW'(T_MAX)) &&
                (t >= CW'(times_q[i]))) begin
                spike_out[i] = SPIKE_FIRED;
            end
        end
    end

    edge_capture #(
        .CW(CW)
    ) u_edge_capture (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == CLEAR),
        .en       (run_en),
        .sig      (res_in),
        .t        (t),
        .captured (captured),
        .t_cap    (t_cap)
    );

    // A capture on the very last step has not reached the capture register yet.
    assign cap_now = run_en && !captured && (res_in == SPIKE_FIRED);
    assign hit     = captured || cap_now;
    assign t_hit   = captured ? t_cap : t;
    assign t_adj   = (t_hit >= CW'(LAT)) ? (t_hit - CW'(LAT)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_time <= '0;
        end else if (run_en && last_step) begin
            out_time <= hit ? TW'(t_adj) : TW'(T_MAX);
        end
    end

endmodule
